dwc_out_collector: RTL and testbench



---
 rtl/dwc_out_collector.sv | 118 +++++++++++
 tb/tb_dwc_out_collector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwc_out_collector.sv
// Collects per-unit, per-row partial sums from the depthwise-conv PU array,
// requantizes them to OUT_W bits and emits one completed row per handshake.
module dwc_out_collector #(
   parameter int UNIT_NUM = 16,
   parameter int ROWS     = 4,
   parameter int ACC_W    = 32,
   parameter int OUT_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [UNIT_NUM*ROWS*ACC_W-1:0] in_sums,
   input  logic [UNIT_NUM*ROWS-1:0]      in_valids,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_relu,
   output logic [UNIT_NUM*OUT_W-1:0]     out_data,
   output logic [$clog2(ROWS)-1:0]       out_row,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          overflow,
   output logic                          misalign
);

   localparam int RW = $clog2(ROWS);
   localparam int DW = UNIT_NUM * OUT_W;
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = -((ACC_W+1)'(1 << (OUT_W-1)));

   logic [ROWS-1:0] pending_q, pending_d;
   logic [DW-1:0]   data_q [ROWS];
   logic [DW-1:0]   data_d [ROWS];
   logic            overflow_q, overflow_d;
   logic            misalign_q, misalign_d;
   logic [RW-1:0]   sel;
   logic            any_pending;
   logic            pop;

   // Computed one bit wider than the input so the rounding add cannot wrap.
   function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] x,
                                                input logic [4:0] sh,
                                                input logic relu);
      logic signed [ACC_W:0] xe, rnd, y;
      xe  = (relu && x < 0) ? '0 : {x[ACC_W-1], x};
      rnd = (sh == 5'd0) ? '0 : ((ACC_W+1)'(1) << (sh - 5'd1));
      y   = (xe + rnd) >>> sh;
      if (y > SAT_MAX)      y = SAT_MAX;
      else if (y < SAT_MIN) y = SAT_MIN;
      return y[OUT_W-1:0];
   endfunction

   always_comb begin
      sel         = '0;
      any_pending = 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (!any_pending && pending_q[r]) begin
            sel         = RW'(r);
            any_pending = 1'b1;
         end
      end
      pop = any_pending && out_ready;
   end

   always_comb begin
      logic          all_s, any_s;
      logic [DW-1:0] row_data;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      misalign_d = misalign_q;
      row_data   = '0;
      all_s      = 1'b0;
      any_s      = 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) data_d[r] = data_q[r];
      if (pop) pending_d[sel] = 1'b0;
      // Pop is cleared first so a capture into the popping slot re-arms it.
      for (int unsigned r = 0; r < ROWS; r++) begin
         all_s = 1'b1;
         any_s = 1'b0;
         for (int unsigned u = 0; u < UNIT_NUM; u++) begin
            all_s = all_s & in_valids[u*ROWS + r];
            any_s = any_s | in_valids[u*ROWS + r];
            row_data[u*OUT_W +: OUT_W] =
               requant(in_sums[(u*ROWS + r)*ACC_W +: ACC_W], cfg_shift, cfg_relu);
         end
         if (any_s && !all_s) begin
            misalign_d = 1'b1;
         end else if (all_s) begin
            if (pending_q[r] && !(pop && sel == RW'(r))) begin
               overflow_d = 1'b1;
            end else begin
               data_d[r]    = row_data;
               pending_d[r] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q  <= '0;
         overflow_q <= 1'b0;
         misalign_q <= 1'b0;
         for (int unsigned r = 0; r < ROWS; r++) data_q[r] <= '0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         misalign_q <= misalign_d;
         for (int unsigned r = 0; r < ROWS; r++) data_q[r] <= data_d[r];
      end
   end

   assign out_valid = any_pending;
   assign busy      = any_pending;
   assign out_row   = sel;
   assign out_data  = any_pending ? data_q[sel] : '0;
   assign overflow  = overflow_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_dwc_out_collector.sv
// Self-checking bench for dwc_out_collector: directed vector table, corner
// sequences and a randomized run against a queue-free arithmetic model.
module tb_dwc_out_collector;

   localparam int UNIT_NUM = 16;
   localparam int ROWS     = 4;
   localparam int ACC_W    = 32;
   localparam int OUT_W    = 8;
   localparam int DW       = UNIT_NUM * OUT_W;

   logic                           clk = 1'b0;
   logic                           rst = 1'b1;
   logic [UNIT_NUM*ROWS*ACC_W-1:0] in_sums = '0;
   logic [UNIT_NUM*ROWS-1:0]       in_valids = '0;
   logic [4:0]                     cfg_shift = 5'd4;
   logic                           cfg_relu = 1'b0;
   logic [DW-1:0]                  out_data;
   logic [$clog2(ROWS)-1:0]        out_row;
   logic                           out_valid;
   logic                           out_ready = 1'b1;
   logic                           busy;
   logic                           overflow;
   logic                           misalign;

   int n_chk  = 0;
   int n_fail = 0;

   dwc_out_collector #(.UNIT_NUM(UNIT_NUM), .ROWS(ROWS), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .in_sums(in_sums), .in_valids(in_valids),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .out_data(out_data),
      .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .overflow(overflow), .misalign(misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      int sum;
      int sh;
      bit relu;
      int exp;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rep(input int v);
      logic [31:0]   t;
      logic [DW-1:0] r;
      t = v;
      for (int u = 0; u < UNIT_NUM; u++) r[u*OUT_W +: OUT_W] = t[OUT_W-1:0];
      return r;
   endfunction

   task automatic strobe_row(input int r, input int sum);
      for (int u = 0; u < UNIT_NUM; u++) begin
         in_sums[(u*ROWS + r)*ACC_W +: ACC_W] = sum;
         in_valids[u*ROWS + r] = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valids = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Floor division for the shift, then saturation, straight from the rules.
   function automatic int ref_q(input int x, input int sh, input bit relu);
      longint v, d, y;
      v = x;
      if (relu && v < 0) v = 0;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      d = longint'(1) << sh;
      if (v >= 0) y = v / d;
      else        y = -(((-v) + d - 1) / d);
      if (y > 127)  y = 127;
      if (y < -128) y = -128;
      return int'(y);
   endfunction

   bit            m_pend [ROWS];
   logic [DW-1:0] m_dat  [ROWS];
   bit            m_ovf, m_mis;

   initial begin
      vecs[0]  = '{100, 4, 0, 6};
      vecs[1]  = '{-100, 4, 0, -6};
      vecs[2]  = '{5000, 4, 0, 127};
      vecs[3]  = '{-3000, 4, 0, -128};
      vecs[4]  = '{-100, 4, 1, 0};
      vecs[5]  = '{5000, 4, 1, 127};
      vecs[6]  = '{-3000, 4, 1, 0};
      vecs[7]  = '{127, 0, 0, 127};
      vecs[8]  = '{-8, 4, 0, 0};
      vecs[9]  = '{-9, 4, 0, -1};
      vecs[10] = '{24, 4, 0, 2};
      vecs[11] = '{23, 4, 0, 1};
      vecs[12] = '{128, 0, 0, 127};
      vecs[13] = '{-129, 0, 0, -128};
      vecs[14] = '{32'h7fffffff, 31, 0, 1};
      vecs[15] = '{32'h80000000, 31, 0, -1};

      // reset state
      #1;
      chk("rst_valid", DW'(out_valid), '0);
      chk("rst_data", out_data, '0);
      chk("rst_row", DW'(out_row), '0);
      chk("rst_flags", DW'({busy, overflow, misalign}), '0);
      @(negedge clk);
      rst = 1'b0;

      // requant table, each row 0 across all units
      foreach (vecs[i]) begin
         @(negedge clk);
         cfg_shift = 5'(vecs[i].sh);
         cfg_relu  = vecs[i].relu;
         out_ready = 1'b1;
         strobe_row(0, vecs[i].sum);
         @(negedge clk);
         in_valids = '0;
         chk($sformatf("vec%0d_valid", i), DW'(out_valid), 1);
         chk($sformatf("vec%0d_row", i), DW'(out_row), 0);
         chk($sformatf("vec%0d_data", i), out_data, rep(vecs[i].exp));
         @(negedge clk);
         chk($sformatf("vec%0d_drain", i), DW'(out_valid), 0);
      end

      // priority: rows 3 and 1 together, row 1 first
      cfg_shift = 5'd4; cfg_relu = 1'b0;
      strobe_row(1, 100);
      strobe_row(3, 160);
      @(negedge clk);
      in_valids = '0;
      chk("prio_first_row", DW'(out_row), 1);
      chk("prio_first_data", out_data, rep(6));
      @(negedge clk);
      chk("prio_second_row", DW'(out_row), 3);
      chk("prio_second_data", out_data, rep(10));
      chk("prio_second_valid", DW'(out_valid), 1);
      @(negedge clk);
      chk("prio_empty", DW'(out_valid), 0);

      // backpressure and overflow
      out_ready = 1'b0;
      strobe_row(2, 160);
      @(negedge clk);
      in_valids = '0;
      chk("bp_hold_row", DW'(out_row), 2);
      chk("bp_no_ovf_yet", DW'(overflow), 0);
      strobe_row(2, 320);
      @(negedge clk);
      in_valids = '0;
      chk("bp_ovf_set", DW'(overflow), 1);
      chk("bp_old_data", out_data, rep(10));
      out_ready = 1'b1;
      chk("bp_pop_valid", DW'(out_valid), 1);
      @(negedge clk);
      chk("bp_single_pop", DW'(out_valid), 0);
      chk("bp_ovf_sticky", DW'(overflow), 1);

      // capture into the slot being popped
      do_reset();
      out_ready = 1'b0;
      strobe_row(2, 160);
      @(negedge clk);
      out_ready = 1'b1;
      strobe_row(2, 320);
      @(negedge clk);
      in_valids = '0;
      chk("popcap_valid", DW'(out_valid), 1);
      chk("popcap_data", out_data, rep(20));
      chk("popcap_no_ovf", DW'(overflow), 0);
      @(negedge clk);
      chk("popcap_drain", DW'(out_valid), 0);

      // misalign: only unit 0 strobes row 1
      in_valids[0*ROWS + 1] = 1'b1;
      @(negedge clk);
      in_valids = '0;
      chk("mis_flag", DW'(misalign), 1);
      chk("mis_no_valid", DW'(out_valid), 0);
      chk("mis_not_busy", DW'(busy), 0);

      // reset mid-operation
      do_reset();
      out_ready = 1'b0;
      strobe_row(0, 100);
      strobe_row(3, 100);
      @(negedge clk);
      in_valids = '0;
      strobe_row(0, 200);
      @(negedge clk);
      in_valids = '0;
      chk("midrst_pre_ovf", DW'(overflow), 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", DW'(out_valid), 0);
      chk("midrst_busy", DW'(busy), 0);
      chk("midrst_flags", DW'({overflow, misalign}), 0);
      chk("midrst_data", out_data, '0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      strobe_row(0, 48);
      @(negedge clk);
      in_valids = '0;
      chk("postrst_valid", DW'(out_valid), 1);
      chk("postrst_data", out_data, rep(3));

      // randomized run against the model
      do_reset();
      for (int r = 0; r < ROWS; r++) begin m_pend[r] = 0; m_dat[r] = '0; end
      m_ovf = 0; m_mis = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         int            sel;
         bit            pop;
         bit            np [ROWS];
         logic [DW-1:0] e_data;
         @(negedge clk);
         sel = -1;
         for (int r = ROWS - 1; r >= 0; r--) if (m_pend[r]) sel = r;
         e_data = (sel >= 0) ? m_dat[sel] : '0;
         chk("rnd_valid", DW'(out_valid), DW'(sel >= 0));
         chk("rnd_row", DW'(out_row), (sel >= 0) ? DW'(sel) : '0);
         chk("rnd_data", out_data, e_data);
         chk("rnd_flags", DW'({busy, overflow, misalign}), DW'({sel >= 0, m_ovf, m_mis}));

         if ($urandom_range(0, 7) == 0) begin
            cfg_shift = 5'($urandom_range(0, 31));
            cfg_relu  = 1'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         in_valids = '0;
         for (int i = 0; i < UNIT_NUM*ROWS; i++)
            in_sums[i*ACC_W +: ACC_W] = ($urandom_range(0, 1) == 1) ? $urandom
                                        : 32'($urandom_range(0, 8000)) - 32'd4000;
         pop = (sel >= 0) && out_ready;
         for (int r = 0; r < ROWS; r++) np[r] = m_pend[r];
         if (pop) np[sel] = 0;
         for (int r = 0; r < ROWS; r++) begin
            int mode;
            mode = $urandom_range(0, 15);
            if (mode >= 10 && mode <= 14) begin
               for (int u = 0; u < UNIT_NUM; u++) in_valids[u*ROWS + r] = 1'b1;
               if (m_pend[r] && !(pop && sel == r)) begin
                  m_ovf = 1;
               end else begin
                  for (int u = 0; u < UNIT_NUM; u++) begin
                     int q;
                     q = ref_q(int'(in_sums[(u*ROWS + r)*ACC_W +: ACC_W]),
                               int'(cfg_shift), cfg_relu);
                     m_dat[r][u*OUT_W +: OUT_W] = 8'(q);
                  end
                  np[r] = 1;
               end
            end else if (mode == 15 && cyc > 400) begin
               int m;
               m = $urandom_range(1, (1 << UNIT_NUM) - 2);
               for (int u = 0; u < UNIT_NUM; u++) in_valids[u*ROWS + r] = m[u];
               m_mis = 1;
            end
         end
         for (int r = 0; r < ROWS; r++) m_pend[r] = np[r];
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
